// File: rtl/uart_tx_arb.sv
// Two-requester arbiter feeding a single registered byte buffer in front of a UART transmitter.
// Define UART_TX_ARB_LINE_LOCK_EN to hold the grant on one requester until it sends 8'h0A or goes idle.
module uart_tx_arb #(
  parameter logic [15:0] LOCK_TIMEOUT = 16'd1024,
  localparam int unsigned CH_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_vld,
  input  logic [CH_W-1:0] req0_ch,
  output logic            req0_rdy,
  input  logic            req1_vld,
  input  logic [CH_W-1:0] req1_ch,
  output logic            req1_rdy,
  output logic            tx_vld,
  output logic [CH_W-1:0] tx_ch,
  input  logic            tx_rdy,
  output logic            owner
);

  localparam logic [CH_W-1:0] NEWLINE = CH_W'(8'h0A);

  logic            tx_vld_q, tx_vld_d;
  logic [CH_W-1:0] tx_ch_q, tx_ch_d;
  logic            owner_q, owner_d;
  logic            gnt_vld_c, gnt_idx_c;
  logic            buf_free_c, accept_c;
  logic [CH_W-1:0] sel_ch_c;

`ifdef UART_TX_ARB_LINE_LOCK_EN
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 16'd1);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic             lock_vld_c;
`endif

  // Grant selection: round-robin on ties, overridden by an active line lock.
  always_comb begin
    gnt_vld_c = req0_vld | req1_vld;
    gnt_idx_c = 1'b0;
    if (req0_vld && req1_vld) begin
      gnt_idx_c = ~owner_q;
    end else if (req1_vld) begin
      gnt_idx_c = 1'b1;
    end
`ifdef UART_TX_ARB_LINE_LOCK_EN
    case (state_q)
      LOCK0: begin
        gnt_vld_c = req0_vld;
        gnt_idx_c = 1'b0;
      end
      LOCK1: begin
        gnt_vld_c = req1_vld;
        gnt_idx_c = 1'b1;
      end
      default: ;
    endcase
`endif
  end

  assign buf_free_c = ~tx_vld_q | tx_rdy;
  assign accept_c   = buf_free_c & gnt_vld_c;
  assign sel_ch_c   = gnt_idx_c ? req1_ch : req0_ch;
  assign req0_rdy   = accept_c & ~gnt_idx_c;
  assign req1_rdy   = accept_c & gnt_idx_c;

  // Output buffer: refill wins over drain so a byte per cycle can stream through.
  always_comb begin
    tx_vld_d = tx_vld_q;
    tx_ch_d  = tx_ch_q;
    owner_d  = owner_q;
    if (accept_c) begin
      tx_vld_d = 1'b1;
      tx_ch_d  = sel_ch_c;
      owner_d  = gnt_idx_c;
    end else if (tx_rdy) begin
      tx_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_vld_q <= 1'b0;
      tx_ch_q  <= '0;
      owner_q  <= 1'b1;
    end else begin
      tx_vld_q <= tx_vld_d;
      tx_ch_q  <= tx_ch_d;
      owner_q  <= owner_d;
    end
  end

`ifdef UART_TX_ARB_LINE_LOCK_EN
  // Lock FSM: newline or an idle owner releases the line.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    lock_vld_c = (state_q == LOCK1) ? req1_vld : req0_vld;
    cnt_inc_c  = (cnt_q == LOCK_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (accept_c && (sel_ch_c != NEWLINE)) begin
          state_d = gnt_idx_c ? LOCK1 : LOCK0;
        end
      end
      default: begin
        if (accept_c && (sel_ch_c == NEWLINE)) begin
          state_d = IDLE;
        end else if (!lock_vld_c) begin
          if (cnt_inc_c == LOCK_LAST) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  // Per-byte arbitration only; the timeout parameter has no effect in this build.
  if (LOCK_TIMEOUT == 16'd0) begin : g_timeout_unused
  end
`endif

  assign tx_vld = tx_vld_q;
  assign tx_ch  = tx_ch_q;
  assign owner  = owner_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: streaming, round-robin or line lock, backpressure, reset.
module tb_uart_tx_arb;

  logic       clk;
  logic       rst_n;
  logic       req0_vld, req1_vld;
  logic [7:0] req0_ch, req1_ch;
  logic       req0_rdy, req1_rdy;
  logic       tx_vld;
  logic [7:0] tx_ch;
  logic       tx_rdy;
  logic       owner;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arb #(.LOCK_TIMEOUT(16'd8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0_vld (req0_vld),
    .req0_ch  (req0_ch),
    .req0_rdy (req0_rdy),
    .req1_vld (req1_vld),
    .req1_ch  (req1_ch),
    .req1_rdy (req1_rdy),
    .tx_vld   (tx_vld),
    .tx_ch    (tx_ch),
    .tx_rdy   (tx_rdy),
    .owner    (owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    req0_vld = 1'b0;
    req1_vld = 1'b0;
    req0_ch  = 8'h00;
    req1_ch  = 8'h00;
    tx_rdy   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tx_vld", 16'(tx_vld), 16'h0);
    chk("rst_tx_ch", 16'(tx_ch), 16'h00);
    chk("rst_owner", 16'(owner), 16'h1);
    tick();
    tick();
    rst_n = 1'b1;

    // Single requester streams "AB"
    req0_vld = 1'b1;
    req0_ch  = 8'h41;
    #1;
    chk("ab_rdy0_a", 16'(req0_rdy), 16'h1);
    chk("ab_rdy1_a", 16'(req1_rdy), 16'h0);
    tick();
    chk("ab_tx_vld_a", 16'(tx_vld), 16'h1);
    chk("ab_tx_ch_a", 16'(tx_ch), 16'h41);
    chk("ab_owner_a", 16'(owner), 16'h0);
    req0_ch = 8'h42;
    #1;
    chk("ab_rdy0_b", 16'(req0_rdy), 16'h1);
    chk("ab_rdy1_b", 16'(req1_rdy), 16'h0);
    tick();
    chk("ab_tx_ch_b", 16'(tx_ch), 16'h42);
    req0_vld = 1'b0;
    tick();
    chk("ab_drain", 16'(tx_vld), 16'h0);

    // Reset while a byte sits in the buffer
    tx_rdy   = 1'b0;
    req0_vld = 1'b1;
    req0_ch  = 8'h55;
    tick();
    chk("mid_tx_vld", 16'(tx_vld), 16'h1);
    chk("mid_owner", 16'(owner), 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_vld", 16'(tx_vld), 16'h0);
    chk("mid_rst_tx_ch", 16'(tx_ch), 16'h00);
    chk("mid_rst_owner", 16'(owner), 16'h1);
    req0_vld = 1'b0;
    tx_rdy   = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_no_replay", 16'(tx_vld), 16'h0);

`ifndef UART_TX_ARB_LINE_LOCK_EN
    // Round-robin contention, requester 0 first after reset
    req0_vld = 1'b1;
    req0_ch  = 8'h30;
    req1_vld = 1'b1;
    req1_ch  = 8'h60;
    #1;
    chk("rr_rdy0_1", 16'(req0_rdy), 16'h1);
    chk("rr_rdy1_1", 16'(req1_rdy), 16'h0);
    tick();
    chk("rr_tx_1", 16'(tx_ch), 16'h30);
    chk("rr_owner_1", 16'(owner), 16'h0);
    req0_ch = 8'h31;
    #1;
    chk("rr_rdy0_2", 16'(req0_rdy), 16'h0);
    chk("rr_rdy1_2", 16'(req1_rdy), 16'h1);
    tick();
    chk("rr_tx_2", 16'(tx_ch), 16'h60);
    chk("rr_owner_2", 16'(owner), 16'h1);
    req1_ch = 8'h61;
    #1;
    chk("rr_rdy0_3", 16'(req0_rdy), 16'h1);
    tick();
    chk("rr_tx_3", 16'(tx_ch), 16'h31);
    req0_ch = 8'h32;
    #1;
    chk("rr_rdy1_4", 16'(req1_rdy), 16'h1);
    tick();
    chk("rr_tx_4", 16'(tx_ch), 16'h61);
    req1_ch = 8'h62;

    // Backpressure for 5 cycles with both requesters waiting
    tx_rdy = 1'b0;
    #1;
    chk("bp_rdy0_0", 16'(req0_rdy), 16'h0);
    chk("bp_rdy1_0", 16'(req1_rdy), 16'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_tx_vld_%0d", i), 16'(tx_vld), 16'h1);
      chk($sformatf("bp_tx_ch_%0d", i), 16'(tx_ch), 16'h61);
      chk($sformatf("bp_rdy0_%0d", i), 16'(req0_rdy), 16'h0);
      chk($sformatf("bp_rdy1_%0d", i), 16'(req1_rdy), 16'h0);
    end
    tx_rdy = 1'b1;
    #1;
    chk("bp_release_rdy0", 16'(req0_rdy), 16'h1);
    tick();
    chk("bp_tx_next", 16'(tx_ch), 16'h32);
    req0_vld = 1'b0;
    #1;
    chk("bp_rdy1_after", 16'(req1_rdy), 16'h1);
    tick();
    chk("bp_tx_next2", 16'(tx_ch), 16'h62);
    req1_vld = 1'b0;
    tick();
    chk("bp_drain", 16'(tx_vld), 16'h0);
`else
    // Line lock: "hi\n" from requester 0 completes before requester 1
    req1_vld = 1'b1;
    req1_ch  = 8'h0A;
    req0_vld = 1'b1;
    req0_ch  = 8'h68;
    #1;
    chk("lk_rdy0_h", 16'(req0_rdy), 16'h1);
    tick();
    chk("lk_tx_h", 16'(tx_ch), 16'h68);
    req0_ch = 8'h69;
    #1;
    chk("lk_rdy1_i", 16'(req1_rdy), 16'h0);
    chk("lk_rdy0_i", 16'(req0_rdy), 16'h1);
    tick();
    chk("lk_tx_i", 16'(tx_ch), 16'h69);
    req0_ch = 8'h0A;
    #1;
    chk("lk_rdy1_nl", 16'(req1_rdy), 16'h0);
    chk("lk_rdy0_nl", 16'(req0_rdy), 16'h1);
    tick();
    chk("lk_tx_nl", 16'(tx_ch), 16'h0A);
    chk("lk_owner_nl", 16'(owner), 16'h0);
    req0_vld = 1'b0;
    #1;
    chk("lk_rdy1_after", 16'(req1_rdy), 16'h1);
    tick();
    chk("lk_tx_r1", 16'(tx_ch), 16'h0A);
    chk("lk_owner_r1", 16'(owner), 16'h1);

    // Timeout: requester 0 locks with one byte then goes idle
    req0_vld = 1'b1;
    req0_ch  = 8'h41;
    req1_ch  = 8'h52;
    #1;
    chk("to_rdy0", 16'(req0_rdy), 16'h1);
    tick();
    chk("to_tx_a", 16'(tx_ch), 16'h41);
    req0_vld = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1;
      chk($sformatf("to_locked_%0d", k), 16'(req1_rdy), 16'h0);
      tick();
    end
    #1;
    chk("to_release", 16'(req1_rdy), 16'h1);
    tick();
    chk("to_tx_r1", 16'(tx_ch), 16'h52);
    chk("to_owner_r1", 16'(owner), 16'h1);
    req1_vld = 1'b0;
    tick();
    chk("to_drain", 16'(tx_vld), 16'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The parameter list SHALL be: LOCK_TIMEOUT, default 16'd1024, cycles a locked owner may stay idle before its lock is released.
REQ-002 The port list SHALL open with clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-003 The next port SHALL be rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The ports SHALL include req0_vld, input, 1, requester 0 has a byte to send.
REQ-005 The ports SHALL include req0_ch, input, 8, the requester 0 byte.
REQ-006 The ports SHALL include req0_rdy, output, 1, the requester 0 byte is accepted this cycle.
REQ-007 The ports SHALL include req1_vld, req1_ch and req1_rdy, with the same widths and meanings as REQ-004 to REQ-006 for requester 1.
REQ-008 The ports SHALL include tx_vld, output, 1, a byte is offered to the shared UART transmitter.
REQ-009 The ports SHALL include tx_ch, output, 8, the byte offered to the transmitter.
REQ-010 The ports SHALL include tx_rdy, input, 1, the transmitter takes tx_ch this cycle.
REQ-011 The ports SHALL include owner, output, 1, the index of the requester currently or last granted.

Function
REQ-012 A byte SHALL transfer on req side when reqN_vld && reqN_rdy, and on the tx side when tx_vld && tx_rdy.
REQ-013 The output buffer SHALL be a single register, so tx_vld/tx_ch are registered and a byte accepted in cycle N appears on tx_vld in cycle N+1.
REQ-014 The buffer SHALL be free when !tx_vld || tx_rdy; simultaneous drain and refill SHALL sustain one byte per cycle.
REQ-015 At most one reqN_rdy SHALL be high in any cycle, and only for the granted requester while the buffer is free.
REQ-016 reqN_rdy SHALL be combinational from the grant, the vld inputs, tx_vld and tx_rdy, and SHALL never depend on reqN_ch.
REQ-017 Grant without lock (state IDLE) SHALL be: only one requester valid gets the grant; both valid gets the requester != owner (round-robin).
REQ-018 owner SHALL update to the granted index on every accepted byte.
REQ-019 tx_ch SHALL hold stable while tx_vld && !tx_rdy.
REQ-020 Neither requester's vld SHALL be dropped or reordered; each requester's bytes SHALL leave in its own input order.
REQ-021 If no requester is valid, the buffer SHALL drain normally and tx_vld SHALL fall after the last byte is taken.

Reset
REQ-022 On rst_n low, asynchronously: tx_vld=0, tx_ch=8'h00, owner=1 (so requester 0 wins the first tie), state IDLE, idle counter 0.
REQ-023 A reset mid-transfer SHALL discard the buffered byte; no partial byte is ever re-presented after reset release.
REQ-024 Outputs SHALL be valid in the first clock edge after rst_n rises.

Configuration
REQ-025 Macro UART_TX_ARB_LINE_LOCK_EN SHALL enable line locking; when undefined, arbitration is per byte (REQ-017) and states LOCK0/LOCK1 and the idle counter are not built.
REQ-026 With the macro, a byte accepted from requester N in IDLE SHALL move the state to LOCKN unless that byte is 8'h0A.
REQ-027 In LOCKN, only requester N SHALL be granted, even if the other requester is valid.
REQ-028 Accepting 8'h0A from requester N SHALL return the state to IDLE, with owner=N.
REQ-029 In LOCKN, the idle counter SHALL increment on each cycle with reqN_vld=0 and clear on any reqN_vld=1.
REQ-030 When the idle counter reaches LOCK_TIMEOUT-1, the state SHALL return to IDLE the next cycle.
REQ-031 Wrap of the idle counter SHALL be impossible because it saturates at LOCK_TIMEOUT-1.

Verification
REQ-032 Single requester: req0 streams "AB", tx_rdy=1 -> tx_ch 0x41 then 0x42 on consecutive cycles, 1 cycle after each accept; req1_rdy stays 0.
REQ-033 Contention, no macro: both requesters valid continuously with 0x30.. and 0x60.. -> tx sequence 0x30,0x60,0x31,0x61 starting with requester 0 after reset.
REQ-034 Backpressure: tx_rdy=0 for 5 cycles with tx_vld=1 -> tx_ch stable, both reqN_rdy=0; tx_rdy=1 -> the next byte follows one per cycle.
REQ-035 Line lock with macro: req0 sends "hi\n" while req1 valid -> tx shows 0x68,0x69,0x0A before any req1 byte.
REQ-036 Timeout with macro, LOCK_TIMEOUT=8: req0 sends 0x41 then idles; req1 valid -> req1 granted exactly 8 cycles after the last req0 vld.
REQ-037 Reset mid-stream: assert rst_n=0 with tx_vld=1 -> tx_vld=0 immediately, owner=1; after release req0 wins the first tie.
